// File: rtl/i2s_audio_tx_pkg.sv
// Shared definitions for the I2S transmit path: frame geometry, slot/word
// types and the offset-binary-12 to signed-16 sample conversion.
// Define I2S_AUDIO_TX_LJ_EN to select left-justified framing.
package i2s_audio_tx_pkg;

    localparam int I2S_SLOTS_PER_FRAME = 32;
    localparam int I2S_WORD_BITS       = 16;
    localparam int SLOT_W              = 5;
    localparam int DIV_W               = 8;

`ifdef I2S_AUDIO_TX_LJ_EN
    // Left-justified: the shift register is exactly one frame of data.
    localparam int SR_BITS = 2 * I2S_WORD_BITS;
`else
    // Standard I2S: one extra bit carries the previous right LSB into slot 0.
    localparam int SR_BITS = 2 * I2S_WORD_BITS + 1;
`endif

    typedef logic [SLOT_W-1:0]        slot_t;
    typedef logic [I2S_WORD_BITS-1:0] word_t;
    typedef logic [SR_BITS-1:0]       shreg_t;

    localparam slot_t SLOT_LAST = slot_t'(I2S_SLOTS_PER_FRAME - 1);

    // Offset binary -> two's complement is an MSB flip; the 12-bit value is
    // then left-aligned in the 16-bit word.
    function automatic word_t ob12_to_s16(input logic [11:0] s);
        return {~s[11], s[10:0], 4'b0000};
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV into bclk and flags the
// cycle in which bclk falls (fall_evt, combinational, one clk wide).
// Ports: clk, rst_n (async low), bclk, fall_evt.
module i2s_bclk_gen
    import i2s_audio_tx_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_evt
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap     = (div_cnt == DIV_LAST);
    // bclk is about to toggle from 1 to 0 on this edge.
    assign fall_evt = wrap & bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// Mono-to-stereo I2S transmitter: latches one 12-bit offset-binary sample per
// frame and shifts it MSB first on both channels. Default build is standard
// I2S (one-bit delay); define I2S_AUDIO_TX_LJ_EN for left-justified.
// Ports: clk, rst_n (async low), sample_in[11:0], mute, sample_strobe,
//        bclk, lrclk, sdata.
module i2s_audio_tx
    import i2s_audio_tx_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample_in,
    input  logic        mute,
    output logic        sample_strobe,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata
);

    logic   fall_evt;
    logic   latch;
    slot_t  slot;
    slot_t  slot_nx;
    word_t  word_nx;
    shreg_t sr;
    shreg_t sr_load;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign slot_nx = slot + slot_t'(1);
    // The fall event entering slot 0 starts a new frame.
    assign latch   = fall_evt & (slot == SLOT_LAST);
    assign word_nx = mute ? '0 : ob12_to_s16(sample_in);

`ifdef I2S_AUDIO_TX_LJ_EN
    assign sr_load = {word_nx, word_nx};
`else
    word_t word;

    // Held word's LSB is the previous right-channel LSB, which the one-bit
    // delay pushes into slot 0 of the new frame.
    assign sr_load = {word[0], word_nx, word_nx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (latch) begin
            word <= word_nx;
        end
    end
`endif

    assign sdata = sr[SR_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot          <= SLOT_LAST;
            lrclk         <= 1'b0;
            sr            <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= latch;
            if (fall_evt) begin
                slot  <= slot_nx;
                // Upper half of the frame is the right channel.
                lrclk <= slot_nx[SLOT_W-1];
                sr    <= latch ? sr_load : (sr << 1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Randomised self-checking bench for i2s_audio_tx (CLK_DIV=2) against a
// frame-level reference model of the serial stream.
module tb_i2s_audio_tx;
    import i2s_audio_tx_pkg::*;

    localparam int D = 2;
    localparam int FR = 64 * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sample_in;
    logic        mute;
    logic        sample_strobe;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    int total  = 0;
    int passed = 0;

    logic [11:0] fs [16];
    bit          fm [16];

    i2s_audio_tx #(
        .CLK_DIV (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_in     (sample_in),
        .mute          (mute),
        .sample_strobe (sample_strobe),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Signed value of the offset-binary sample, scaled by 16, mod 2^16.
    function automatic logic [15:0] ref_word(input int f);
        int v;
        if (fm[f]) return 16'h0000;
        v = (int'(fs[f]) - 2048) * 16;
        return 16'(v);
    endfunction

    task automatic ref_outs(input int t, output logic eb, output logic el,
                            output logic es, output logic ed);
        int k, s, f;
        logic [15:0] w, wp;
        k  = t / (2 * D);
        eb = 1'((t / D) % 2);
        el = 1'b0;
        es = 1'b0;
        ed = 1'b0;
        if (k > 0) begin
            s  = (k - 1) % 32;
            f  = (k - 1) / 32;
            w  = ref_word(f);
            wp = (f == 0) ? 16'h0000 : ref_word(f - 1);
            es = (t % (2 * D) == 0) && (s == 0);
            el = (s >= 16);
`ifdef I2S_AUDIO_TX_LJ_EN
            if (s < 16) ed = w[15 - s];
            else        ed = w[31 - s];
`else
            if (s == 0)       ed = wp[0];
            else if (s <= 16) ed = w[16 - s];
            else              ed = w[32 - s];
`endif
        end
    endtask

    task automatic check_t(input int t);
        logic eb, el, es, ed;
        ref_outs(t, eb, el, es, ed);
        chk($sformatf("bclk@%0d", t), 32'(bclk), 32'(eb));
        chk($sformatf("lrclk@%0d", t), 32'(lrclk), 32'(el));
        chk($sformatf("strobe@%0d", t), 32'(sample_strobe), 32'(es));
        chk($sformatf("sdata@%0d", t), 32'(sdata), 32'(ed));
    endtask

    // Frame inputs are held steady around each latch; elsewhere they are
    // random noise that must be ignored.
    task automatic drive(input int t);
        int g, l;
        g = (t + FR / 2) / FR;
        l = FR * g + 2 * D - 1;
        if (t >= l - 2 && t <= l + 2) begin
            sample_in = fs[g];
            mute      = fm[g];
        end else begin
            sample_in = 12'($urandom);
            mute      = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_seg(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0);
        #1;
        check_t(0);
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            check_t(t);
            drive(t);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bclk"}, 32'(bclk), 32'd0);
        chk({tag, "_lrclk"}, 32'(lrclk), 32'd0);
        chk({tag, "_sdata"}, 32'(sdata), 32'd0);
        chk({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        sample_in = 12'h000;
        mute      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");

        chk("conv_800", 32'(ob12_to_s16(12'h800)), 32'h0000);
        chk("conv_fff", 32'(ob12_to_s16(12'hFFF)), 32'h7FF0);
        chk("conv_000", 32'(ob12_to_s16(12'h000)), 32'h8000);
        chk("conv_801", 32'(ob12_to_s16(12'h801)), 32'h0010);

        for (int i = 0; i < 16; i++) begin
            fs[i] = 12'($urandom);
            fm[i] = ($urandom_range(0, 7) == 0);
        end
        fs[0] = 12'hFFF; fm[0] = 1'b0;
        fs[1] = 12'hFFF; fm[1] = 1'b0;
        fs[2] = 12'h000; fm[2] = 1'b0;
        fs[3] = 12'h800; fm[3] = 1'b0;
        fs[4] = 12'hABC; fm[4] = 1'b1;
        fs[5] = 12'hABC; fm[5] = 1'b0;
        run_seg(FR * 9);

        // Async reset mid-frame: slot 9 of frame 1.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid0");
        for (int i = 0; i < 16; i++) begin
            fs[i] = 12'($urandom);
            fm[i] = 1'b0;
        end
        fs[0] = 12'hFFF;
        fs[1] = 12'hFFF;
        run_seg(84 * D + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            fs[i] = 12'($urandom);
            fm[i] = ($urandom_range(0, 5) == 0);
        end
        run_seg(FR * 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
